dff_bank_arbiter: RTL and testbench
===================================

// Module: dff_bank_arbiter
// PURPOSE
//  Shares one bank of NREG x WIDTH D-flip-flop registers between NREQ requesters.
//  Each requester issues WRITE / CLEAR / SET / READ commands. A round-robin
//  arbiter and a 2-state FSM serialise them, one command per 2 cycles.
//  Sits between control masters and the flop bank; register contents are also
//  exported in parallel for downstream datapath use.
// PARAMETERS
//  NREQ   4  number of requesters (>=2)
//  NREG   8  number of registers in bank (>=2); AW = $clog2(NREG) (localparam)
//  WIDTH  8  bits per register
// PORTS
//  clk    in   1           clock, all state updates on posedge
//  rst    in   1           synchronous reset, active-high
//  req    in   NREQ        request per requester, level, held until ack
//  cmd    in   2*NREQ      per requester: 00 WRITE, 01 CLEAR, 10 SET, 11 READ
//  addr   in   AW*NREQ     per requester register index
//  wdata  in   WIDTH*NREQ  per requester write data (WRITE only)
//  gnt    out  NREQ        one-hot grant, valid in EXEC only
//  ack    out  1           1-cycle completion pulse (EXEC)
//  err    out  1           with ack: addr >= NREG, bank untouched
//  rdata  out  WIDTH       register value after the op, valid with ack
//  busy   out  1           1 while in EXEC
//  q_all  out  NREG*WIDTH  parallel view of bank, reg i at [i*WIDTH +: WIDTH]
// BEHAVIOUR
//  Reset (rst=1 at posedge): all regs=0, state=IDLE, rr pointer=0, gnt=0,
//   ack=0, err=0, rdata=0, busy=0. Reset overrides everything, incl. mid-EXEC:
//   the pending op is dropped, no write, no ack.
//  FSM: IDLE -> EXEC when any req=1 at posedge; EXEC -> IDLE always (1 cycle).
//  Arbitration (IDLE): winner = first requester with req=1 searching from rr
//   pointer upward, wrapping NREQ-1 -> 0. Winner's index, cmd, addr, wdata are
//   latched at the IDLE->EXEC edge; later input changes do not affect the op.
//  Pointer update: on entering EXEC with winner w, rr = (w+1) mod NREQ.
//  EXEC cycle: gnt[w]=1, busy=1, ack=1; bank update at the EXEC->IDLE edge
//   is already performed in rdata combinationally from latched op:
//   WRITE reg<=wdata, CLEAR reg<=0, SET reg<={WIDTH{1'b1}}, READ no change.
//   rdata = post-op value of reg[addr] (=wdata / 0 / all-ones / current).
//   q_all reflects the update from the cycle after EXEC.
//  err: latched addr >= NREG -> err=1 with ack, no write, rdata=0.
//  Handshake: requester must drop req at the posedge where it samples ack=1;
//   a req still high in the following IDLE is a new request. Dropping req
//   before ack is illegal (op still completes).
//  Latency: req rising before edge E -> ack in cycle after E (if winner).
//   Throughput max 1 op / 2 cycles; idle bank holds all values.
//  No starvation: with all NREQ requesting continuously, each is served once
//   per NREQ ops.
// TESTING
//  T1 reset: drive rst=1 with all req=1 for 2 cycles -> ack=0, gnt=0, q_all=0.
//  T2 single: req[2] WRITE addr3 data 8'hA5 -> ack+gnt=4'b0100 next cycle,
//   rdata=A5; then READ addr3 from req[0] -> rdata=A5, q_all[31:24]=A5.
//  T3 fairness: all 4 req held (re-raised after ack) from reset -> grant order
//   0,1,2,3,0,1; SET by req1 addr0 -> reg0=FF, CLEAR by req3 addr0 -> reg0=00.
//  T4 wrap: rr=3, req={1,0,0,1} -> req3 first, then req0.
//  T5 error: NREG=6, WRITE addr7 -> ack=1, err=1, q_all unchanged.
//  T6 reset mid-op: rst=1 during EXEC of WRITE addr1 8'h3C -> no ack, reg1=0,
//   rr=0.

Source files
------------

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
//   Shares one bank of NREG x WIDTH flip-flop registers between NREQ requesters.
//   A round-robin arbiter picks one request per IDLE cycle. A two-state FSM
//   (IDLE/EXEC) then executes it, so the block completes at most one command
//   every two cycles.
// Ports
//   clk    : clock; all state updates on posedge
//   rst    : synchronous active-high reset
//   req    : per-requester request (level, held until ack)
//   cmd    : per-requester command, 2 bits each (WRITE/CLEAR/SET/READ)
//   addr   : per-requester register index, AW bits each
//   wdata  : per-requester write data, WIDTH bits each
//   gnt    : one-hot grant, asserted during EXEC
//   ack    : one-cycle completion pulse during EXEC
//   err    : with ack, flags an out-of-range address (bank untouched)
//   rdata  : post-operation value of the addressed register, valid with ack
//   busy   : high while in EXEC
//   q_all  : parallel view of the bank, reg i at [i*WIDTH +: WIDTH]
module dff_bank_arbiter #(
   parameter  int unsigned NREQ  = 4,
   parameter  int unsigned NREG  = 8,
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned AW    = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [2*NREQ-1:0]     cmd,
   input  logic [AW*NREQ-1:0]    addr,
   input  logic [WIDTH*NREQ-1:0] wdata,
   output logic [NREQ-1:0]       gnt,
   output logic                  ack,
   output logic                  err,
   output logic [WIDTH-1:0]      rdata,
   output logic                  busy,
   output logic [NREG*WIDTH-1:0] q_all
);

   localparam int unsigned RW = $clog2(NREQ);

   typedef enum logic {IDLE, EXEC} state_t;
   typedef enum logic [1:0] {CMD_WRITE, CMD_CLEAR, CMD_SET, CMD_READ} cmd_t;

   state_t           state;
   logic [RW-1:0]    rr;
   logic [RW-1:0]    win;
   logic             found;
   cmd_t             op_cmd;
   logic [AW-1:0]    op_addr;
   logic [WIDTH-1:0] op_wdata;
   logic [WIDTH-1:0] cur;
   logic [1:0]       sel_cmd;
   logic [AW-1:0]    sel_addr;
   logic [WIDTH-1:0] sel_wdata;
   logic [WIDTH-1:0] bank [NREG];

   // Round-robin search starting at rr, wrapping at NREQ-1.
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!found && req[(32'(rr) + k) % NREQ]) begin
            found = 1'b1;
            win   = RW'((32'(rr) + k) % NREQ);
         end
      end
   end

   assign sel_cmd   = cmd[win*2 +: 2];
   assign sel_addr  = addr[win*AW +: AW];
   assign sel_wdata = wdata[win*WIDTH +: WIDTH];

   // Decoded read of the latched address; loop avoids indexing past NREG.
   always_comb begin
      cur = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (op_addr == AW'(i)) cur = bank[i];
      end
   end

   // rdata shows the value the register will hold after the EXEC->IDLE edge.
   always_comb begin
      rdata = '0;
      if (state == EXEC && !err) begin
         case (op_cmd)
            CMD_WRITE: rdata = op_wdata;
            CMD_CLEAR: rdata = '0;
            CMD_SET:   rdata = '1;
            default:   rdata = cur;
         endcase
      end
   end

   always_comb begin
      q_all = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         q_all[i*WIDTH +: WIDTH] = bank[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr       <= '0;
         gnt      <= '0;
         ack      <= 1'b0;
         err      <= 1'b0;
         busy     <= 1'b0;
         op_cmd   <= CMD_WRITE;
         op_addr  <= '0;
         op_wdata <= '0;
         for (int unsigned i = 0; i < NREG; i++) bank[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  state    <= EXEC;
                  op_cmd   <= cmd_t'(sel_cmd);
                  op_addr  <= sel_addr;
                  op_wdata <= sel_wdata;
                  err      <= ({1'b0, sel_addr} >= (AW+1)'(NREG));
                  gnt      <= NREQ'(1) << win;
                  ack      <= 1'b1;
                  busy     <= 1'b1;
                  rr       <= (win == RW'(NREQ-1)) ? '0 : win + 1'b1;
               end
            end
            EXEC: begin
               if (!err) begin
                  for (int unsigned i = 0; i < NREG; i++) begin
                     if (op_addr == AW'(i)) begin
                        case (op_cmd)
                           CMD_WRITE: bank[i] <= op_wdata;
                           CMD_CLEAR: bank[i] <= '0;
                           CMD_SET:   bank[i] <= '1;
                           default:   bank[i] <= bank[i];
                        endcase
                     end
                  end
               end
               state <= IDLE;
               gnt   <= '0;
               ack   <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed testbench for dff_bank_arbiter: a default 4x8x8 instance plus
// an NREG=6 instance for out-of-range addresses.
module tb_dff_bank_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [7:0]  cmd;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic [3:0]  gnt;
   logic        ack, err, busy;
   logic [7:0]  rdata;
   logic [63:0] q_all;

   logic [3:0]  req6;
   logic [7:0]  cmd6;
   logic [11:0] addr6;
   logic [31:0] wdata6;
   logic [3:0]  gnt6;
   logic        ack6, err6, busy6;
   logic [7:0]  rdata6;
   logic [47:0] q_all6;

   int checks;
   int errors;

   dff_bank_arbiter #(.NREQ(4), .NREG(8), .WIDTH(8)) u_dut (
      .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
      .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .busy(busy), .q_all(q_all)
   );

   dff_bank_arbiter #(.NREQ(4), .NREG(6), .WIDTH(8)) u_dut6 (
      .clk(clk), .rst(rst), .req(req6), .cmd(cmd6), .addr(addr6), .wdata(wdata6),
      .gnt(gnt6), .ack(ack6), .err(err6), .rdata(rdata6), .busy(busy6), .q_all(q_all6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [1:0] c, input logic [2:0] a, input logic [7:0] d);
      cmd[r*2 +: 2]   = c;
      addr[r*3 +: 3]  = a;
      wdata[r*8 +: 8] = d;
   endtask

   task automatic set_req6(input int r, input logic [1:0] c, input logic [2:0] a, input logic [7:0] d);
      cmd6[r*2 +: 2]   = c;
      addr6[r*3 +: 3]  = a;
      wdata6[r*8 +: 8] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'hF;
      tick();
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
      tick();
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
      checks++;
      if (q_all !== 64'h0) begin errors++; $display("FAIL reset_q_all got %h exp 0", q_all); end
      checks++;
      if (busy !== 1'b0 || ack !== 1'b0 || rdata !== 8'h00) begin
         errors++; $display("FAIL reset_outs got busy=%b ack=%b rdata=%h exp 0/0/00", busy, ack, rdata);
      end
      req = 4'h0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      set_req(2, 2'b00, 3'd3, 8'hA5);
      req = 4'b0100;
      tick();
      checks++;
      if (ack !== 1'b1 || gnt !== 4'b0100) begin
         errors++; $display("FAIL single_ack_gnt got ack=%b gnt=%b exp 1/0100", ack, gnt);
      end
      checks++;
      if (rdata !== 8'hA5 || busy !== 1'b1) begin
         errors++; $display("FAIL single_rdata got rdata=%h busy=%b exp a5/1", rdata, busy);
      end
      req = 4'b0000;
      tick();
      checks++;
      if (q_all[31:24] !== 8'hA5 || ack !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL single_write got reg3=%h ack=%b busy=%b exp a5/0/0", q_all[31:24], ack, busy);
      end
      set_req(0, 2'b11, 3'd3, 8'h00);
      req = 4'b0001;
      tick();
      checks++;
      if (gnt !== 4'b0001 || rdata !== 8'hA5) begin
         errors++; $display("FAIL single_read got gnt=%b rdata=%h exp 0001/a5", gnt, rdata);
      end
      req = 4'b0000;
      tick();
      checks++;
      if (q_all !== 64'h00000000_A5000000) begin
         errors++; $display("FAIL single_q_all got %h exp 00000000a5000000", q_all);
      end
   endtask

   task automatic test_fairness();
      int         exp_order[6];
      logic [7:0] exp_rd[6];
      exp_order = '{0, 1, 2, 3, 0, 1};
      exp_rd    = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};
      rst = 1'b1;
      req = 4'h0;
      tick();
      rst = 1'b0;
      set_req(0, 2'b11, 3'd0, 8'h00);
      set_req(1, 2'b10, 3'd0, 8'h00);
      set_req(2, 2'b11, 3'd0, 8'h00);
      set_req(3, 2'b01, 3'd0, 8'h00);
      req = 4'hF;
      for (int n = 0; n < 6; n++) begin
         tick();
         checks++;
         if (gnt !== (4'b0001 << exp_order[n])) begin
            errors++; $display("FAIL fair_gnt op%0d got %b exp %b", n, gnt, 4'b0001 << exp_order[n]);
         end
         checks++;
         if (rdata !== exp_rd[n]) begin
            errors++; $display("FAIL fair_rdata op%0d got %h exp %h", n, rdata, exp_rd[n]);
         end
         req[exp_order[n]] = 1'b0;
         tick();
         req[exp_order[n]] = 1'b1;
      end
      req = 4'h0;
      tick();
      checks++;
      if (q_all[7:0] !== 8'hFF) begin
         errors++; $display("FAIL fair_reg0 got %h exp ff", q_all[7:0]);
      end
   endtask

   task automatic test_wrap();
      // rr is 2 after the fairness run; serving req2 moves it to 3.
      set_req(2, 2'b11, 3'd0, 8'h00);
      set_req(3, 2'b11, 3'd0, 8'h00);
      set_req(0, 2'b11, 3'd0, 8'h00);
      req = 4'b0100;
      tick();
      checks++;
      if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_pre got %b exp 0100", gnt); end
      req = 4'b0000;
      tick();
      req = 4'b1001;
      tick();
      checks++;
      if (gnt !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b exp 1000", gnt); end
      req[3] = 1'b0;
      tick();
      tick();
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL wrap_second got %b exp 0001", gnt); end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_error();
      set_req6(0, 2'b00, 3'd5, 8'h5A);
      req6 = 4'b0001;
      tick();
      checks++;
      if (ack6 !== 1'b1 || err6 !== 1'b0 || rdata6 !== 8'h5A) begin
         errors++; $display("FAIL err_valid got ack=%b err=%b rdata=%h exp 1/0/5a", ack6, err6, rdata6);
      end
      req6 = 4'b0000;
      tick();
      set_req6(0, 2'b00, 3'd7, 8'hFF);
      req6 = 4'b0001;
      tick();
      checks++;
      if (ack6 !== 1'b1 || err6 !== 1'b1 || rdata6 !== 8'h00 || gnt6 !== 4'b0001) begin
         errors++; $display("FAIL err_addr7 got ack=%b err=%b rdata=%h gnt=%b exp 1/1/00/0001", ack6, err6, rdata6, gnt6);
      end
      req6 = 4'b0000;
      tick();
      checks++;
      if (q_all6 !== 48'h5A_0000000000 || err6 !== 1'b0) begin
         errors++; $display("FAIL err_q_all7 got %h err=%b exp 5a0000000000/0", q_all6, err6);
      end
      set_req6(0, 2'b10, 3'd6, 8'h00);
      req6 = 4'b0001;
      tick();
      checks++;
      if (ack6 !== 1'b1 || err6 !== 1'b1) begin
         errors++; $display("FAIL err_addr6 got ack=%b err=%b exp 1/1", ack6, err6);
      end
      req6 = 4'b0000;
      tick();
      checks++;
      if (q_all6 !== 48'h5A_0000000000) begin
         errors++; $display("FAIL err_q_all6 got %h exp 5a0000000000", q_all6);
      end
   endtask

   task automatic test_reset_mid_op();
      // rr is 1 after the wrap test; serving req1 would leave it at 2.
      set_req(1, 2'b00, 3'd1, 8'h3C);
      req = 4'b0010;
      tick();
      checks++;
      if (gnt !== 4'b0010 || ack !== 1'b1) begin
         errors++; $display("FAIL midrst_exec got gnt=%b ack=%b exp 0010/1", gnt, ack);
      end
      rst = 1'b1;
      req = 4'b0000;
      tick();
      checks++;
      if (ack !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_outs got ack=%b gnt=%b busy=%b exp 0/0000/0", ack, gnt, busy);
      end
      checks++;
      if (q_all[15:8] !== 8'h00) begin
         errors++; $display("FAIL midrst_reg1 got %h exp 00", q_all[15:8]);
      end
      rst = 1'b0;
      set_req(0, 2'b11, 3'd1, 8'h00);
      set_req(3, 2'b11, 3'd1, 8'h00);
      req = 4'b1001;
      tick();
      checks++;
      if (gnt !== 4'b0001 || rdata !== 8'h00) begin
         errors++; $display("FAIL midrst_rr got gnt=%b rdata=%h exp 0001/00", gnt, rdata);
      end
      req = 4'b0000;
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      req    = 4'h0;
      cmd    = '0;
      addr   = '0;
      wdata  = '0;
      req6   = 4'h0;
      cmd6   = '0;
      addr6  = '0;
      wdata6 = '0;
      test_reset();
      test_single();
      test_fairness();
      test_wrap();
      test_error();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
